// File: rtl/game_ctrl_if.sv
// Signal bundle between the game controller and the pong datapath/top level.
// The controller attaches through the slave modport.
interface game_ctrl_if;
  logic       refr_tick;
  logic       btn_start;
  logic       hit;
  logic       miss;
  logic       graph_still;
  logic       ball_reset;
  logic [3:0] score_tens;
  logic [3:0] score_ones;
  logic [1:0] lives;
  logic       game_over;
  logic [1:0] state;

  modport master (
    output refr_tick, btn_start, hit, miss,
    input  graph_still, ball_reset, score_tens, score_ones, lives, game_over, state
  );

  modport slave (
    input  refr_tick, btn_start, hit, miss,
    output graph_still, ball_reset, score_tens, score_ones, lives, game_over, state
  );
endinterface

// File: rtl/game_ctrl.sv
// Pong game controller: start/play/new-ball/game-over sequencing, BCD score,
// remaining lives and frame-based hold timer. All outputs come straight from flops.
module game_ctrl #(
  parameter int unsigned LIVES       = 3,
  parameter int unsigned WAIT_FRAMES = 120
) (
  input  logic        clk,
  input  logic        reset,
  game_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    NEWGAME = 2'd0,
    PLAY    = 2'd1,
    NEWBALL = 2'd2,
    OVER    = 2'd3
  } state_t;

  localparam logic [1:0] LIVES_INIT = 2'(LIVES);
  localparam logic [7:0] WAIT_INIT  = 8'(WAIT_FRAMES);

  state_t     state_q, state_d;
  logic [3:0] score_tens_q, score_tens_d;
  logic [3:0] score_ones_q, score_ones_d;
  logic [1:0] lives_q, lives_d;
  logic [7:0] timer_q, timer_d;
  logic       btn_prev_q, btn_prev_d;
  logic       ball_reset_q, ball_reset_d;
  logic       graph_still_q, graph_still_d;
  logic       game_over_q, game_over_d;
  logic       start_edge;

  always_comb begin
    start_edge   = bus.btn_start & ~btn_prev_q;
    btn_prev_d   = bus.btn_start;
    state_d      = state_q;
    score_tens_d = score_tens_q;
    score_ones_d = score_ones_q;
    lives_d      = lives_q;
    timer_d      = timer_q;
    ball_reset_d = 1'b0;

    unique case (state_q)
      NEWGAME: begin
        if (start_edge) begin
          state_d      = PLAY;
          ball_reset_d = 1'b1;
          score_tens_d = '0;
          score_ones_d = '0;
          lives_d      = LIVES_INIT;
        end
      end
      PLAY: begin
        // A miss in the same cycle as a hit wins; the hit is dropped.
        if (bus.miss) begin
          lives_d = (lives_q != 2'd0) ? lives_q - 2'd1 : 2'd0;
          timer_d = WAIT_INIT;
          state_d = (lives_q <= 2'd1) ? OVER : NEWBALL;
        end else if (bus.hit) begin
          if (score_ones_q == 4'd9) begin
            score_ones_d = '0;
            score_tens_d = (score_tens_q == 4'd9) ? 4'd0 : score_tens_q + 4'd1;
          end else begin
            score_ones_d = score_ones_q + 4'd1;
          end
        end
      end
      NEWBALL, OVER: begin
        if (bus.refr_tick) begin
          if (timer_q <= 8'd1) begin
            timer_d = '0;
            if (state_q == NEWBALL) begin
              state_d      = PLAY;
              ball_reset_d = 1'b1;
            end else begin
              state_d = NEWGAME;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: state_d = NEWGAME;
    endcase

    // Decode the flag outputs from the next state so they register alongside it.
    graph_still_d = (state_d != PLAY);
    game_over_d   = (state_d == OVER);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= NEWGAME;
      score_tens_q  <= '0;
      score_ones_q  <= '0;
      lives_q       <= LIVES_INIT;
      timer_q       <= '0;
      btn_prev_q    <= 1'b1;
      ball_reset_q  <= 1'b0;
      graph_still_q <= 1'b1;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      score_tens_q  <= score_tens_d;
      score_ones_q  <= score_ones_d;
      lives_q       <= lives_d;
      timer_q       <= timer_d;
      btn_prev_q    <= btn_prev_d;
      ball_reset_q  <= ball_reset_d;
      graph_still_q <= graph_still_d;
      game_over_q   <= game_over_d;
    end
  end

  assign bus.graph_still = graph_still_q;
  assign bus.ball_reset  = ball_reset_q;
  assign bus.score_tens  = score_tens_q;
  assign bus.score_ones  = score_ones_q;
  assign bus.lives       = lives_q;
  assign bus.game_over   = game_over_q;
  assign bus.state       = state_q;

endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 Parameter LIVES, default 3: lives at game start; range 1..3.
REQ-002 Parameter WAIT_FRAMES, default 120: frames the ball is held after a miss or game over (2 s at 60 Hz); range 1..255.
REQ-003 clk  input  1  system clock; all state changes on the rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 refr_tick  input  1  one-cycle pulse, once per frame at the start of vertical blank.
REQ-006 btn_start  input  1  debounced start-button level.
REQ-007 hit  input  1  one-cycle pulse from the datapath: ball hit the paddle.
REQ-008 miss  input  1  one-cycle pulse from the datapath: ball passed the paddle edge.
REQ-009 graph_still  output  1  1 = datapath freezes ball motion.
REQ-010 ball_reset  output  1  one-cycle pulse: datapath recentres the ball.
REQ-011 score_tens, score_ones  output  4 each  BCD score.
REQ-012 lives  output  2  remaining lives.
REQ-013 game_over  output  1  1 while in OVER.
REQ-014 state  output  2  NEWGAME=0, PLAY=1, NEWBALL=2, OVER=3.

Function
REQ-015 The FSM has exactly four states: NEWGAME, PLAY, NEWBALL and OVER.
REQ-016 The block registers btn_start each cycle; start_edge = btn_start & ~btn_prev, and btn_prev resets to 1 so a button held through reset does not start a game.
REQ-017 NEWGAME: graph_still=1; on start_edge -> PLAY, with ball_reset=1 that cycle, score cleared to 00, lives loaded with LIVES.
REQ-018 PLAY: graph_still=0; on hit, the score increments by 1 in BCD (ones 9 -> 0 carries to tens; 99 -> 00 wraps), registered one cycle after the pulse.
REQ-019 PLAY: on miss, lives decrements and the frame timer loads WAIT_FRAMES; if lives was 1 -> OVER, else -> NEWBALL.
REQ-020 In PLAY, simultaneous hit and miss: miss wins, hit is discarded, score unchanged.
REQ-021 hit and miss are ignored in NEWGAME, NEWBALL and OVER.
REQ-022 NEWBALL: graph_still=1; the timer decrements by 1 only on refr_tick; on the refr_tick that takes the timer from 1 to 0 -> PLAY with ball_reset=1.
REQ-023 OVER: graph_still=1, game_over=1; the timer counts as in NEWBALL; at expiry -> NEWGAME; score and lives hold their values, so the final score stays displayed.
REQ-024 The frame timer is 8 bits and never underflows; it is ignored outside NEWBALL and OVER.
REQ-025 ball_reset is high for exactly one clk cycle per PLAY entry and is never asserted in any other case.
REQ-026 All outputs are registered or decoded from registered state only; there is no combinational path from any input to any output.
REQ-027 lives never goes below 0, and score never exceeds BCD 99.

Reset
REQ-028 While reset=0: state=NEWGAME, graph_still=1, ball_reset=0, score=00, lives=LIVES, game_over=0, timer=0, btn_prev=1.
REQ-029 Reset asserted mid-game (any state) takes effect immediately and asynchronously; no pulse from before reset survives its release.
REQ-030 The first transition after reset release requires a fresh 0->1 edge on btn_start.

Verification
REQ-031 Release reset with btn_start=1, then hold it high for 10 cycles -> state stays NEWGAME; drop and raise btn_start -> state=PLAY, ball_reset=1 for one cycle, lives=3, score=00.
REQ-032 In PLAY, apply 100 hit pulses -> score passes 09->10, 98->99, then wraps to 00; lives stays 3.
REQ-033 In PLAY with lives=3, apply one miss -> lives=2, state=NEWBALL, graph_still=1; 119 refr_ticks -> still NEWBALL; 120th -> PLAY with ball_reset=1.
REQ-034 Apply hit and miss in the same cycle with score=05 -> score stays 05, lives decrements, state=NEWBALL.
REQ-035 Apply three misses (waiting out NEWBALL between them) -> lives=0, state=OVER, game_over=1, score held; after 120 refr_ticks -> NEWGAME; start_edge -> score=00, lives=3.
REQ-036 Assert reset during NEWBALL with timer=50 -> all outputs immediately at REQ-028 values; hit pulses while in NEWGAME have no effect.
